// File: rtl/mul_div_unit.sv
// Sequential 8-bit unsigned multiply/divide unit for a small register-file datapath.
// Multiply is shift-add (16-bit product), divide is restoring (8-bit quotient and
// remainder). Each operation takes eight one-bit iterations. A divide with a zero
// divisor skips the iterations and completes at once with a saturated quotient.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on acceptance
// RUN   | eight iterations, one bit per cycle, busy=1
// DONE  | one-cycle completion: done and load_enable pulse, results presented
module mul_div_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a_data,
  input  logic [7:0] b_data,
  input  logic [1:0] dest_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       load_enable,
  output logic [1:0] destination_select,
  output logic [7:0] result_hi,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  dest_q, dest_d;
  // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
  logic [15:0] acc_q, acc_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load_q, load_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  hi_q, hi_d;
  logic [1:0]  dsel_q, dsel_d;
  logic        dbz_q, dbz_d;

  logic [15:0] step_mul;
  logic [15:0] step_div;
  logic [8:0]  rem_trial;
  logic [8:0]  rem_diff;

  // One iteration of each algorithm, computed from the current accumulator.
  always_comb begin
    step_mul  = b_q[cnt_q] ? (acc_q + ({8'h00, a_q} << cnt_q)) : acc_q;
    // Shift the remainder/dividend pair left by one; the upper 9 bits are the trial remainder.
    rem_trial = acc_q[15:7];
    rem_diff  = rem_trial - {1'b0, b_q};
    if (rem_trial >= {1'b0, b_q}) begin
      step_div = {rem_diff[7:0], acc_q[6:0], 1'b1};
    end else begin
      step_div = {rem_trial[7:0], acc_q[6:0], 1'b0};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    acc_d   = acc_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load_d  = 1'b0;
    data_d  = data_q;
    hi_d    = hi_q;
    dsel_d  = dsel_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          a_d    = a_data;
          b_d    = b_data;
          dest_d = dest_in;
          cnt_d  = 3'd0;
          if (op && (b_data == 8'h00)) begin
            state_d = DONE;
            done_d  = 1'b1;
            load_d  = 1'b1;
            data_d  = 8'hFF;
            hi_d    = a_data;
            dbz_d   = 1'b1;
            dsel_d  = dest_in;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            acc_d   = op ? {8'h00, a_data} : 16'h0000;
          end
        end
      end
      RUN: begin
        acc_d = op_q ? step_div : step_mul;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
          load_d  = 1'b1;
          data_d  = acc_d[7:0];
          hi_d    = acc_d[15:8];
          dbz_d   = 1'b0;
          dsel_d  = dest_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand latches and output registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      dest_q  <= 2'b00;
      acc_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= 8'h00;
      hi_q    <= 8'h00;
      dsel_q  <= 2'b00;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      dsel_q  <= dsel_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign load_enable        = load_q;
  assign data               = data_q;
  assign result_hi          = hi_q;
  assign destination_select = dsel_q;
  assign div_by_zero        = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a cycle-level behavioural model (plain * / % arithmetic and a
// countdown of remaining busy cycles) is compared against the DUT every cycle, and
// directed operations pin results, latency and busy length to literal values.
module tb_mul_div_unit;

  logic       clk = 1'b0;
  logic       reset, start, op;
  logic [7:0] a_data, b_data;
  logic [1:0] dest_in;
  logic       busy, done, load_enable, div_by_zero;
  logic [7:0] data, result_hi;
  logic [1:0] destination_select;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_data(a_data), .b_data(b_data), .dest_in(dest_in),
    .busy(busy), .done(done), .data(data), .load_enable(load_enable),
    .destination_select(destination_select), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model state
  bit         m_valid   = 1'b0;
  int         m_left    = 0;
  bit         m_in_done = 1'b0;
  logic       ml_op;
  logic [7:0] ml_a, ml_b;
  logic [1:0] ml_dest;
  logic       exp_busy, exp_done, exp_load, exp_dbz;
  logic [7:0] exp_data, exp_hi;
  logic [1:0] exp_dsel;

  task automatic m_complete();
    int p;
    exp_done  = 1'b1;
    exp_load  = 1'b1;
    exp_dsel  = ml_dest;
    m_in_done = 1'b1;
    if (!ml_op) begin
      p        = int'(ml_a) * int'(ml_b);
      exp_data = p[7:0];
      exp_hi   = p[15:8];
      exp_dbz  = 1'b0;
    end else if (ml_b == 8'h00) begin
      exp_data = 8'hFF;
      exp_hi   = ml_a;
      exp_dbz  = 1'b1;
    end else begin
      exp_data = ml_a / ml_b;
      exp_hi   = ml_a % ml_b;
      exp_dbz  = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_valid   = 1'b1;
      m_left    = 0;
      m_in_done = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_load  = 1'b0;
      exp_data  = 8'h00;
      exp_hi    = 8'h00;
      exp_dsel  = 2'b00;
      exp_dbz   = 1'b0;
    end else if (m_valid) begin
      exp_done = 1'b0;
      exp_load = 1'b0;
      if (m_in_done) begin
        m_in_done = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_complete();
      end else if (start) begin
        ml_op   = op;
        ml_a    = a_data;
        ml_b    = b_data;
        ml_dest = dest_in;
        if (op && b_data == 8'h00) m_complete();
        else m_left = 8;
      end
      exp_busy = (m_left > 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("load_enable", load_enable, exp_load);
      chk("data", data, exp_data);
      chk("result_hi", result_hi, exp_hi);
      chk("destination_select", destination_select, exp_dsel);
      chk("div_by_zero", div_by_zero, exp_dbz);
    end
  end

  // One operation; optional noise changes operands and pulses start while running.
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] d, input logic [7:0] lo, input logic [7:0] hi,
                        input logic dz, input int lat, input bit noise);
    int cycles;
    int busy_cnt;
    bit seen;
    cycles = 0; busy_cnt = 0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a_data = a; b_data = b; dest_in = d;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (noise) begin
        a_data = ~a; b_data = b + 8'd1; op = ~o; dest_in = ~d;
        if (cycles >= 2 && cycles <= 4) start = 1'b1;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    chk("latency", cycles, lat);
    chk("busy_cycles", busy_cnt, (lat == 1) ? 0 : 8);
    chk("lit_data", data, lo);
    chk("lit_result_hi", result_hi, hi);
    chk("lit_div_by_zero", div_by_zero, dz);
    chk("lit_dest", destination_select, d);
    chk("lit_load", load_enable, 1'b1);
    chk("model_pin_data", exp_data, lo);
    chk("model_pin_hi", exp_hi, hi);
  endtask

  initial begin
    int dones;
    int busies;
    reset = 1'b0; start = 1'b0; op = 1'b0;
    a_data = 8'h00; b_data = 8'h00; dest_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_hi", result_hi, 8'h00);
    chk("rst_dsel", destination_select, 2'b00);
    chk("rst_dbz", div_by_zero, 1'b0);
    reset = 1'b1;

    run_op(1'b0, 8'd7,   8'd6,   2'd2, 8'h2A, 8'h00, 1'b0, 9, 1'b0);
    run_op(1'b0, 8'd200, 8'd3,   2'd0, 8'h58, 8'h02, 1'b0, 9, 1'b0);
    run_op(1'b1, 8'd50,  8'd0,   2'd3, 8'hFF, 8'h32, 1'b1, 1, 1'b0);
    run_op(1'b0, 8'd255, 8'd255, 2'd1, 8'h01, 8'hFE, 1'b0, 9, 1'b0);
    run_op(1'b1, 8'd100, 8'd7,   2'd1, 8'h0E, 8'h02, 1'b0, 9, 1'b0);
    run_op(1'b1, 8'd9,   8'd0,   2'd0, 8'hFF, 8'h09, 1'b1, 1, 1'b0);
    run_op(1'b1, 8'd255, 8'd1,   2'd2, 8'hFF, 8'h00, 1'b0, 9, 1'b1);
    run_op(1'b0, 8'd13,  8'd17,  2'd3, 8'hDD, 8'h00, 1'b0, 9, 1'b1);
    run_op(1'b1, 8'd7,   8'd200, 2'd0, 8'h00, 8'h07, 1'b0, 9, 1'b0);

    // Reset in cycle c+4 of a multiply: operation aborted, no done afterwards.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_data = 8'd9; b_data = 8'd9; dest_in = 2'd3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", data, 8'h00);
    chk("abort_hi", result_hi, 8'h00);
    chk("abort_dsel", destination_select, 2'b00);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);

    // Reset overrides a simultaneous start.
    reset = 1'b0; start = 1'b1; op = 1'b0; a_data = 8'd3; b_data = 8'd3;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    busies = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy === 1'b1) busies++;
    end
    chk("reset_beats_start", busies, 0);

    run_op(1'b0, 8'd12, 8'd11, 2'd1, 8'h84, 8'h00, 1'b0, 9, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-low reset; sampled on clk rising edge; 0 = reset.
REQ-004 start  in  1  request to begin an operation; sampled on clk rising edge.
REQ-005 op  in  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 a_data  in  8  operand A (multiplicand / dividend), from register-file port A.
REQ-007 b_data  in  8  operand B (multiplier / divisor), from register-file port B.
REQ-008 dest_in  in  2  register-file destination for the result.
REQ-009 busy  out  1  operation in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 data  out  8  result to register-file write data: product low byte / quotient.
REQ-012 load_enable  out  1  register-file write strobe.
REQ-013 destination_select  out  2  register-file write address.
REQ-014 result_hi  out  8  product high byte / remainder.
REQ-015 div_by_zero  out  1  last divide had b_data = 0.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 All outputs SHALL be registered.
REQ-018 In IDLE with start=1 at an edge (cycle c), the block SHALL latch a_data, b_data, op and dest_in, clear the iteration counter, and enter RUN.
REQ-019 Operands SHALL be used only as latched; input changes after acceptance SHALL have no effect.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 RUN SHALL last exactly 8 cycles (c+1..c+8), one bit per cycle, using a 3-bit counter.
REQ-022 Multiply SHALL be shift-add with a 16-bit product.
REQ-023 Divide SHALL be restoring division producing an 8-bit quotient and an 8-bit remainder.
REQ-024 busy SHALL be 1 in cycles c+1..c+8 and 0 otherwise.
REQ-025 After the last RUN cycle the block SHALL enter DONE (cycle c+9) for one cycle; done=1 and load_enable=1 in that cycle only.
REQ-026 In DONE, destination_select SHALL equal the latched dest_in.
REQ-027 In DONE, data SHALL equal the product[7:0] or the quotient.
REQ-028 result_hi SHALL equal the product[15:8] or the remainder.
REQ-029 DONE SHALL always return to IDLE in cycle c+10.
REQ-030 data, result_hi and div_by_zero SHALL hold their values until the next DONE.
REQ-031 destination_select SHALL hold its last value when load_enable=0.
REQ-032 Divide with latched b=0: the block SHALL skip RUN and enter DONE in cycle c+1.
REQ-033 In that case: data=8'hFF, result_hi=latched A, div_by_zero=1, load_enable=1.
REQ-034 Any completed multiply or nonzero divide SHALL clear div_by_zero.
REQ-035 Arithmetic SHALL be unsigned only.
REQ-036 No overflow flag; the product never exceeds 16 bits.

Reset
REQ-037 With reset=0 at an edge, the state SHALL become IDLE and busy, done and load_enable SHALL be 0.
REQ-038 Also on reset: data=8'h00, result_hi=8'h00, destination_select=2'b00, div_by_zero=0, counter=0.
REQ-039 Reset mid-RUN or in DONE SHALL abort the operation with no load_enable pulse after the reset edge.
REQ-040 reset=0 SHALL override a simultaneous start.

Verification
REQ-041 Multiply: start, op=0, a=7, b=6, dest=2 in cycle c -> busy c+1..c+8; c+9: done=1, load_enable=1, data=8'h2A, result_hi=8'h00, destination_select=2'b10.
REQ-042 Multiply wide: a=200, b=3 -> data=8'h58, result_hi=8'h02.
REQ-043 Multiply max: a=255, b=255 -> data=8'h01, result_hi=8'hFE.
REQ-044 Divide: op=1, a=100, b=7, dest=1 -> c+9: data=8'h0E, result_hi=8'h02, div_by_zero=0, destination_select=2'b01.
REQ-045 Divide by zero: a=50, b=0 -> c+1: done=1, data=8'hFF, result_hi=8'h32, div_by_zero=1; busy never 1.
REQ-046 Start during RUN changes no result and gives no extra done; operand change after start has no effect.
REQ-047 Reset=0 at c+4 -> IDLE, all outputs at reset values, no done in c+9; a new start is then accepted normally.
